// File: rtl/load_aligner.sv
// Load data aligner: extracts and extends the addressed byte/halfword/word from the memory
// read word one cycle after issue, holding the result across stalls. Optional: LOAD_MISALIGN_EN.
module load_aligner (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        req_valid,
   input  logic [5:0]  req_op,
   input  logic [1:0]  req_addr_lo,
   input  logic [4:0]  req_rd,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   output logic [31:0] out_data,
   output logic [4:0]  out_rd,
   output logic        out_misalign
);

   localparam logic [1:0] StEmpty = 2'd0;
   localparam logic [1:0] StLive  = 2'd1;
   localparam logic [1:0] StHeld  = 2'd2;

   localparam logic [5:0] OpLb  = 6'b100000;
   localparam logic [5:0] OpLh  = 6'b100001;
   localparam logic [5:0] OpLw  = 6'b100011;
   localparam logic [5:0] OpLbu = 6'b100100;
   localparam logic [5:0] OpLhu = 6'b100101;

   logic [1:0]  state_q, state_d;
   logic [5:0]  op_q, op_d;
   logic [1:0]  addr_q, addr_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] hold_q, hold_d;

   logic        is_load;
   logic        accept;
   logic        present;
   logic [31:0] src_word;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] ext_data;

   always_comb begin
      is_load = (req_op == OpLb) || (req_op == OpLh) || (req_op == OpLw) ||
                (req_op == OpLbu) || (req_op == OpLhu);
      accept  = req_valid && !stall && is_load;
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      hold_d  = hold_q;

      case (state_q)
         StEmpty: begin
            if (accept) state_d = StLive;
         end
         StLive: begin
            if (stall) begin
               // Memory data is not held, so capture it on the first stalled cycle.
               state_d = StHeld;
               hold_d  = mem_rdata;
            end else if (accept) begin
               state_d = StLive;
            end else begin
               state_d = StEmpty;
            end
         end
         StHeld: begin
            if (stall)       state_d = StHeld;
            else if (accept) state_d = StLive;
            else             state_d = StEmpty;
         end
         default: state_d = StEmpty;
      endcase

      if (accept) begin
         op_d   = req_op;
         addr_d = req_addr_lo;
         rd_d   = req_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StEmpty;
         op_q    <= '0;
         addr_q  <= '0;
         rd_q    <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      present  = (state_q != StEmpty);
      src_word = (state_q == StLive) ? mem_rdata : hold_q;

      unique case (addr_q)
         2'd0:    byte_sel = src_word[7:0];
         2'd1:    byte_sel = src_word[15:8];
         2'd2:    byte_sel = src_word[23:16];
         default: byte_sel = src_word[31:24];
      endcase
      half_sel = addr_q[1] ? src_word[31:16] : src_word[15:0];

      case (op_q)
         OpLb:    ext_data = {{24{byte_sel[7]}}, byte_sel};
         OpLbu:   ext_data = {24'd0, byte_sel};
         OpLh:    ext_data = {{16{half_sel[15]}}, half_sel};
         OpLhu:   ext_data = {16'd0, half_sel};
         default: ext_data = src_word;
      endcase
   end

`ifdef LOAD_MISALIGN_EN
   logic misalign;

   always_comb begin
      misalign = (((op_q == OpLh) || (op_q == OpLhu)) && addr_q[0]) ||
                 ((op_q == OpLw) && (addr_q != 2'd0));
      out_valid    = present && !misalign;
      out_misalign = present && misalign;
      out_data     = (present && !misalign) ? ext_data : 32'd0;
      out_rd       = present ? rd_q : 5'd0;
   end
`else
   always_comb begin
      out_valid    = present;
      out_misalign = 1'b0;
      out_data     = present ? ext_data : 32'd0;
      out_rd       = present ? rd_q : 5'd0;
   end
`endif

endmodule

// File: tb/tb_load_aligner.sv
// Scoreboard bench for load_aligner: expected results are queued when the memory word is
// driven and compared whenever the DUT presents a result.
module tb_load_aligner;

   localparam logic [5:0] OpLb  = 6'b100000;
   localparam logic [5:0] OpLh  = 6'b100001;
   localparam logic [5:0] OpLw  = 6'b100011;
   localparam logic [5:0] OpLbu = 6'b100100;
   localparam logic [5:0] OpLhu = 6'b100101;
   localparam logic [5:0] OpSw  = 6'b101011;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        mis;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        req_valid;
   logic [5:0]  req_op;
   logic [1:0]  req_addr_lo;
   logic [4:0]  req_rd;
   logic [31:0] mem_rdata;
   logic        out_valid;
   logic [31:0] out_data;
   logic [4:0]  out_rd;
   logic        out_misalign;

   exp_t        sb_q[$];
   exp_t        mon_e;
   logic        mon_pres;
   logic        mon_en;
   int          n_checks;
   int          n_fail;

   logic        acc_v;
   logic [5:0]  acc_op;
   logic [1:0]  acc_a;
   logic [4:0]  acc_rd;

   logic [5:0]  op_tab [6];

   load_aligner u_dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .req_valid    (req_valid),
      .req_op       (req_op),
      .req_addr_lo  (req_addr_lo),
      .req_rd       (req_rd),
      .mem_rdata    (mem_rdata),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_rd       (out_rd),
      .out_misalign (out_misalign)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic is_load(input logic [5:0] op);
      return (op == OpLb) || (op == OpLh) || (op == OpLw) || (op == OpLbu) || (op == OpLhu);
   endfunction

   function automatic exp_t model(input logic [5:0] op, input logic [1:0] a, input logic [4:0] rd,
                                  input logic [31:0] w);
      exp_t        e;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] sh;
      sh = w >> (8 * a);
      b  = sh[7:0];
      h  = a[1] ? w[31:16] : w[15:0];
      case (op)
         OpLb:    e.data = {{24{b[7]}}, b};
         OpLbu:   e.data = {24'd0, b};
         OpLh:    e.data = {{16{h[15]}}, h};
         OpLhu:   e.data = {16'd0, h};
         default: e.data = w;
      endcase
      e.rd  = rd;
      e.mis = 1'b0;
`ifdef LOAD_MISALIGN_EN
      e.mis = (((op == OpLh) || (op == OpLhu)) && a[0]) || ((op == OpLw) && (a != 2'd0));
      if (e.mis) e.data = 32'd0;
`endif
      return e;
   endfunction

   // One cycle of stimulus; mem is the word returned for last cycle's accepted request.
   task automatic drive(input logic v, input logic [5:0] op, input logic [1:0] a,
                        input logic [4:0] rd, input logic [31:0] mem, input logic st,
                        input logic r);
      req_valid   = v;
      req_op      = op;
      req_addr_lo = a;
      req_rd      = rd;
      mem_rdata   = mem;
      stall       = st;
      rst         = r;
      if (acc_v) sb_q.push_back(model(acc_op, acc_a, acc_rd, mem));
      acc_v  = v && !st && !r && is_load(op);
      acc_op = op;
      acc_a  = a;
      acc_rd = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [31:0] mem);
      drive(1'b0, 6'd0, 2'd0, 5'd0, mem, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_pres = out_valid || out_misalign;
         check_val("present", {31'd0, mon_pres}, {31'd0, sb_q.size() != 0});
         if (mon_pres && sb_q.size() != 0) begin
            mon_e = sb_q[0];
            check_val("data", out_data, mon_e.data);
            check_val("rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
            check_val("misalign", {31'd0, out_misalign}, {31'd0, mon_e.mis});
            check_val("valid", {31'd0, out_valid}, {31'd0, !mon_e.mis});
            if (!stall) void'(sb_q.pop_front());
         end else if (!mon_pres) begin
            check_val("empty_data", out_data, 32'd0);
            check_val("empty_rd", {27'd0, out_rd}, 32'd0);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      mon_en   = 1'b0;
      acc_v    = 1'b0;
      acc_op   = '0;
      acc_a    = '0;
      acc_rd   = '0;
      op_tab   = '{OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSw};

      drive(1'b0, 6'd0, 2'd0, 5'd0, 32'd0, 1'b0, 1'b1);
      drive(1'b0, 6'd0, 2'd0, 5'd0, 32'd0, 1'b0, 1'b1);
      mon_en = 1'b1;
      idle(32'hFFFF_FFFF);

      // lb then lbu at addr 3, back to back, same word.
      drive(1'b1, OpLb, 2'd3, 5'd1, 32'h0, 1'b0, 1'b0);
      drive(1'b1, OpLbu, 2'd3, 5'd2, 32'h80FF_1234, 1'b0, 1'b0);
      idle(32'h80FF_1234);
      idle(32'h0);

      // lh addr 2, lhu addr 0, lw addr 0.
      drive(1'b1, OpLh, 2'd2, 5'd3, 32'h0, 1'b0, 1'b0);
      drive(1'b1, OpLhu, 2'd0, 5'd4, 32'h9ABC_0001, 1'b0, 1'b0);
      drive(1'b1, OpLw, 2'd0, 5'd5, 32'h9ABC_0001, 1'b0, 1'b0);
      idle(32'h9ABC_0001);
      idle(32'h0);

      // lw rd=7 held across a three-cycle stall while memory data changes.
      drive(1'b1, OpLw, 2'd0, 5'd7, 32'h0, 1'b0, 1'b0);
      drive(1'b1, OpLb, 2'd0, 5'd9, 32'h1122_3344, 1'b1, 1'b0);
      drive(1'b1, OpLb, 2'd0, 5'd9, 32'hDEAD_BEEF, 1'b1, 1'b0);
      drive(1'b0, 6'd0, 2'd0, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
      idle(32'hDEAD_BEEF);
      idle(32'hDEAD_BEEF);

      // Stall in the acceptance cycle: nothing accepted.
      drive(1'b1, OpLw, 2'd0, 5'd3, 32'h0, 1'b1, 1'b0);
      idle(32'h5555_5555);

      // Back-to-back lbu addr 0 and 1.
      drive(1'b1, OpLbu, 2'd0, 5'd10, 32'h0, 1'b0, 1'b0);
      drive(1'b1, OpLbu, 2'd1, 5'd11, 32'h0000_AA55, 1'b0, 1'b0);
      idle(32'h0000_AA55);
      idle(32'h0);

      // Reset the cycle after acceptance, then reset in the acceptance cycle.
      drive(1'b1, OpLw, 2'd0, 5'd12, 32'h0, 1'b0, 1'b0);
      drive(1'b0, 6'd0, 2'd0, 5'd0, 32'hCAFE_F00D, 1'b0, 1'b1);
      idle(32'h1234_5678);
      drive(1'b1, OpLw, 2'd0, 5'd13, 32'h0, 1'b0, 1'b1);
      idle(32'hABCD_EF01);
      drive(1'b1, OpLh, 2'd2, 5'd14, 32'h0, 1'b0, 1'b0);
      idle(32'h8001_7FFF);

      // sw is not a load.
      drive(1'b1, OpSw, 2'd0, 5'd15, 32'h0, 1'b0, 1'b0);
      idle(32'h7777_7777);

      // lh addr 1: misaligned when enabled, low halfword otherwise.
      drive(1'b1, OpLh, 2'd1, 5'd16, 32'h0, 1'b0, 1'b0);
      idle(32'h1234_5678);
      idle(32'h0);

      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(1) == 1, op_tab[$urandom_range(5)], 2'($urandom_range(3)),
               5'($urandom_range(31)), $urandom, $urandom_range(3) == 0, 1'b0);
      end
      idle($urandom);
      idle($urandom);
      idle(32'h0);

      check_val("sb_drain", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
